// File: rtl/lfsr_range_sampler_if.sv
// rtl/lfsr_range_sampler_if.sv - valid/ready output stream carrying bounded random values
//
// Ports (signals):
//   rnd_out   : head-of-FIFO value, driven by the sampler
//   rnd_valid : FIFO non-empty, driven by the sampler
//   rnd_ready : consumer accepts rnd_out this cycle, driven by the consumer
// Modports:
//   master : the sampler side (drives rnd_out/rnd_valid)
//   slave  : the consumer side (drives rnd_ready)

interface lfsr_range_sampler_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] rnd_out;
    logic             rnd_valid;
    logic             rnd_ready;

    modport master (
        output rnd_out,
        output rnd_valid,
        input  rnd_ready
    );

    modport slave (
        input  rnd_out,
        input  rnd_valid,
        output rnd_ready
    );

endinterface

// File: rtl/lfsr_range_sampler.sv
// rtl/lfsr_range_sampler.sv - rejection sampler turning an LFSR stream into bounded values
//
// Ports:
//   clk        : system clock, all state updates on the rising edge
//   reset      : synchronous active-high reset, clears all state
//   enable     : rnd_in is sampled this cycle
//   rnd_in     : LFSR state
//   limit      : exclusive upper bound, 0 means accept everything
//   rnd        : output stream (master modport: rnd_out, rnd_valid, rnd_ready)
//   count      : current FIFO occupancy
//   reject_cnt : saturating count of out-of-range samples
//   stuck      : sticky flag, rnd_in repeated STUCK_CYCLES times in a row

module lfsr_range_sampler #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int STUCK_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         rnd_in,
    input  logic [WIDTH-1:0]         limit,
    lfsr_range_sampler_if.master     rnd,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               reject_cnt,
    output logic                     stuck
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(STUCK_CYCLES + 1);

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [RW-1:0] RUN_MAX    = RW'(STUCK_CYCLES);
    localparam logic [RW-1:0] RUN_TRIP   = RW'(STUCK_CYCLES - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_next;
    logic [WIDTH-1:0] prev_sample;
    logic [RW-1:0]    run_cnt;
    logic [RW-1:0]    run_next;

    logic in_range;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic reject;
    logic same;

    assign in_range = (limit == '0) || (rnd_in < limit);
    assign empty    = (count == '0);
    assign full     = (count == COUNT_FULL);
    assign pop      = !empty && rnd.rnd_ready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push     = enable && in_range && (!full || pop);
    assign reject   = enable && !in_range;
    assign rd_next  = rd_ptr + AW'(1);

    assign rnd.rnd_out   = head_q;
    assign rnd.rnd_valid = !empty;

    // The head is kept in its own register so rnd_out reads 0 after reset and
    // holds the last head while empty instead of exposing a stale slot.
    always_comb begin
        head_next = head_q;
        if (pop) begin
            if (count == CW'(1)) begin
                if (push) begin
                    head_next = rnd_in;
                end
            end else begin
                // With two or more entries the next slot is valid; a concurrent
                // push when full lands on the slot being vacated, not rd_next.
                head_next = mem[rd_next];
            end
        end else if (empty && push) begin
            head_next = rnd_in;
        end
    end

    always_comb begin
        same     = (rnd_in == prev_sample);
        run_next = '0;
        if (same) begin
            run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RW'(1);
        end
    end

    // Storage needs no reset: occupancy and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= rnd_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            head_q      <= '0;
            reject_cnt  <= '0;
            prev_sample <= '0;
            run_cnt     <= '0;
            stuck       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            head_q <= head_next;

            if (reject && (reject_cnt != 8'hFF)) begin
                reject_cnt <= reject_cnt + 8'd1;
            end

            // prev_sample starts at 0, so an all-zero LFSR trips after
            // STUCK_CYCLES-1 enabled cycles.
            if (enable) begin
                prev_sample <= rnd_in;
                run_cnt     <= run_next;
                if (same && (run_next >= RUN_TRIP)) begin
                    stuck <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// tb/tb_lfsr_range_sampler.sv - scoreboard bench for lfsr_range_sampler

module tb_lfsr_range_sampler;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] rnd_in;
    logic [7:0] limit;
    logic [2:0] count;
    logic [7:0] reject_cnt;
    logic       stuck;

    int tests_run;
    int tests_failed;
    int pop_count;
    bit seen [256];

    logic [7:0] exp_q [$];

    lfsr_range_sampler_if #(.WIDTH(8)) rnd_if ();

    lfsr_range_sampler #(.WIDTH(8), .DEPTH(DEPTH), .STUCK_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .rnd_in     (rnd_in),
        .limit      (limit),
        .rnd        (rnd_if),
        .count      (count),
        .reject_cnt (reject_cnt),
        .stuck      (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the current inputs; scoreboard predicts pops/pushes.
    task automatic cycle();
        int   sz;
        logic popm;
        sz = exp_q.size();
        if (reset) begin
            exp_q.delete();
        end else begin
            tests_run++;
            if (rnd_if.rnd_valid !== (sz > 0)) begin
                tests_failed++;
                $display("FAIL valid: got %b exp %b", rnd_if.rnd_valid, (sz > 0));
            end
            popm = (sz > 0) && rnd_if.rnd_ready;
            if (popm) begin
                tests_run++;
                if (rnd_if.rnd_out !== exp_q[0]) begin
                    tests_failed++;
                    $display("FAIL pop_data: got %h exp %h", rnd_if.rnd_out, exp_q[0]);
                end
                seen[exp_q[0]] = 1'b1;
                pop_count++;
                void'(exp_q.pop_front());
            end
            if (enable && ((limit == 8'd0) || (rnd_in < limit)) && ((sz < DEPTH) || popm)) begin
                exp_q.push_back(rnd_in);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1; rnd_in = 8'hC3; limit = 8'h10; rnd_if.rnd_ready = 1'b1;
        do_reset(2);
        tests_run++;
        if ({count, rnd_if.rnd_valid, rnd_if.rnd_out, reject_cnt, stuck} !== {3'd0, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got cnt=%0d v=%b out=%h rej=%0d stuck=%b exp all zero",
                     count, rnd_if.rnd_valid, rnd_if.rnd_out, reject_cnt, stuck);
        end
    endtask

    task automatic test_basic_order();
        logic [7:0] vals [4];
        vals = '{8'h5A, 8'h2D, 8'h96, 8'h4B};
        enable = 1'b0; do_reset(2);
        limit = 8'h00; enable = 1'b1; rnd_if.rnd_ready = 1'b0;
        foreach (vals[i]) begin
            rnd_in = vals[i];
            cycle();
        end
        tests_run++;
        if (count !== 3'd4 || rnd_if.rnd_valid !== 1'b1 || rnd_if.rnd_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL basic_fill: got cnt=%0d v=%b out=%h exp cnt=4 v=1 out=5a",
                     count, rnd_if.rnd_valid, rnd_if.rnd_out);
        end
        rnd_in = 8'h25;
        cycle();
        tests_run++;
        if (count !== 3'd4 || rnd_if.rnd_out !== 8'h5A || reject_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL basic_drop: got cnt=%0d out=%h rej=%0d exp cnt=4 out=5a rej=0",
                     count, rnd_if.rnd_out, reject_cnt);
        end
        enable = 1'b0; rnd_if.rnd_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        tests_run++;
        if (count !== 3'd0 || rnd_if.rnd_valid !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL basic_drain: got cnt=%0d v=%b exp cnt=0 v=0", count, rnd_if.rnd_valid);
        end
    endtask

    task automatic test_rejection();
        logic [7:0] vals [4];
        vals = '{8'h03, 8'h06, 8'hFF, 8'h05};
        enable = 1'b0; do_reset(1);
        limit = 8'd6; enable = 1'b1; rnd_if.rnd_ready = 1'b0;
        foreach (vals[i]) begin
            rnd_in = vals[i];
            cycle();
        end
        tests_run++;
        if (count !== 3'd2 || reject_cnt !== 8'd2) begin
            tests_failed++;
            $display("FAIL reject_basic: got cnt=%0d rej=%0d exp cnt=2 rej=2", count, reject_cnt);
        end
        enable = 1'b0; rnd_if.rnd_ready = 1'b1;
        for (int i = 0; i < 2; i++) cycle();
        enable = 1'b1; rnd_in = 8'hFF;
        for (int i = 0; i < 300; i++) cycle();
        tests_run++;
        if (reject_cnt !== 8'd255 || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL reject_sat: got rej=%0d cnt=%0d exp rej=255 cnt=0", reject_cnt, count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] vals [4];
        vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        enable = 1'b0; do_reset(1);
        limit = 8'h00; enable = 1'b1; rnd_if.rnd_ready = 1'b0;
        foreach (vals[i]) begin
            rnd_in = vals[i];
            cycle();
        end
        rnd_if.rnd_ready = 1'b1; rnd_in = 8'h11;
        cycle();
        tests_run++;
        if (count !== 3'd4 || rnd_if.rnd_out !== 8'hB2) begin
            tests_failed++;
            $display("FAIL full_pushpop: got cnt=%0d out=%h exp cnt=4 out=b2", count, rnd_if.rnd_out);
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        tests_run++;
        if (rnd_if.rnd_valid !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL full_drain: got v=%b exp v=0", rnd_if.rnd_valid);
        end
    endtask

    task automatic test_stuck();
        logic ever;
        enable = 1'b0; do_reset(1);
        limit = 8'h00; rnd_if.rnd_ready = 1'b1; enable = 1'b1; rnd_in = 8'h00;
        cycle(); cycle();
        tests_run++;
        if (stuck !== 1'b0) begin
            tests_failed++;
            $display("FAIL stuck_early: got %b exp 0", stuck);
        end
        cycle();
        tests_run++;
        if (stuck !== 1'b1) begin
            tests_failed++;
            $display("FAIL stuck_set: got %b exp 1", stuck);
        end
        rnd_in = 8'hB8;
        cycle();
        tests_run++;
        if (stuck !== 1'b1) begin
            tests_failed++;
            $display("FAIL stuck_sticky: got %b exp 1", stuck);
        end
        do_reset(1);
        tests_run++;
        if (stuck !== 1'b0) begin
            tests_failed++;
            $display("FAIL stuck_reset: got %b exp 0", stuck);
        end
        ever = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rnd_in = (i % 2 == 0) ? 8'h01 : 8'h02;
            cycle();
            ever = ever | stuck;
        end
        tests_run++;
        if (ever !== 1'b0) begin
            tests_failed++;
            $display("FAIL stuck_alt: got %b exp 0", ever);
        end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) cycle();
    endtask

    task automatic test_reset_mid();
        logic [7:0] vals [4];
        vals = '{8'h10, 8'h20, 8'hF0, 8'h30};
        enable = 1'b0; do_reset(1);
        limit = 8'h80; enable = 1'b1; rnd_if.rnd_ready = 1'b0;
        foreach (vals[i]) begin
            rnd_in = vals[i];
            cycle();
        end
        tests_run++;
        if (count !== 3'd3 || reject_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL mid_setup: got cnt=%0d rej=%0d exp cnt=3 rej=1", count, reject_cnt);
        end
        rnd_in = 8'h77;
        do_reset(1);
        enable = 1'b0;
        tests_run++;
        if ({count, rnd_if.rnd_valid, rnd_if.rnd_out, reject_cnt} !== {3'd0, 1'b0, 8'h00, 8'h00}) begin
            tests_failed++;
            $display("FAIL mid_reset: got cnt=%0d v=%b out=%h rej=%0d exp all zero",
                     count, rnd_if.rnd_valid, rnd_if.rnd_out, reject_cnt);
        end
        cycle();
        tests_run++;
        if (count !== 3'd0) begin
            tests_failed++;
            $display("FAIL mid_nopush: got cnt=%0d exp 0", count);
        end
    endtask

    task automatic test_live_lfsr();
        logic [7:0] s;
        int distinct;
        enable = 1'b0; do_reset(1);
        foreach (seen[i]) seen[i] = 1'b0;
        pop_count = 0;
        limit = 8'h00; rnd_if.rnd_ready = 1'b1; enable = 1'b1;
        s = 8'h01;
        for (int i = 0; i < 255; i++) begin
            rnd_in = s;
            cycle();
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) cycle();
        distinct = 0;
        foreach (seen[i]) if (seen[i]) distinct++;
        tests_run++;
        if (pop_count != 255 || distinct != 255 || seen[0]) begin
            tests_failed++;
            $display("FAIL live_pops: got pops=%0d distinct=%0d zero=%b exp 255 255 0",
                     pop_count, distinct, seen[0]);
        end
        tests_run++;
        if (stuck !== 1'b0) begin
            tests_failed++;
            $display("FAIL live_stuck: got %b exp 0", stuck);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        pop_count = 0;
        reset = 1'b1;
        enable = 1'b0;
        rnd_in = 8'h00;
        limit = 8'h00;
        rnd_if.rnd_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_order();
        test_rejection();
        test_full_push_pop();
        test_stuck();
        test_reset_mid();
        test_live_lfsr();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lfsr_range_sampler.md
Name: lfsr_range_sampler

Overview:
- Downstream consumer of the 8-bit `lfsr` output (`shift_seed`).
- Converts the raw pseudo-random stream into bounded values in [0, limit-1] by rejection sampling.
- Buffers accepted values in a small FIFO and hands them out over a valid/ready handshake to game/control logic.
- Also flags an LFSR that has locked up.

Parameters:
- WIDTH, 8, width of the random sample and output value.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- STUCK_CYCLES, 4, consecutive identical samples that raise `stuck`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when high, `rnd_in` is sampled this cycle.
- rnd_in  input  WIDTH  LFSR state, wired from `lfsr.shift_seed`.
- limit  input  WIDTH  exclusive upper bound; 0 means 2^WIDTH (accept all).
- rnd_out  output  WIDTH  head-of-FIFO value.
- rnd_valid  output  1  FIFO non-empty.
- rnd_ready  input  1  consumer accepts `rnd_out` this cycle.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- reject_cnt  output  8  saturating count of rejected samples.
- stuck  output  1  sticky lock-up flag.

Behaviour:
- Reset (synchronous, active-high): at the first rising edge with `reset`=1, clear all state:
  - count=0, rnd_valid=0, rnd_out=0, reject_cnt=0, stuck=0.
  - Stuck run counter=0; previous-sample register=0; FIFO pointers=0.
  - Reset overrides all other inputs in that cycle. Reset mid-operation discards buffered data.
- Sample qualification, evaluated each cycle with enable=1:
  - in_range = (limit==0) || (rnd_in < limit), unsigned compare.
  - Push when in_range and the FIFO has room. Room means count<DEPTH, or count==DEPTH with a pop in the same cycle.
  - Reject when !in_range: reject_cnt increments, saturating at 255, and no push occurs.
  - Sample in range but FIFO full with no pop: the sample is dropped silently. No reject count, no push.
  - enable=0: no push, no reject, and the stuck logic holds.
- Pop: occurs when rnd_valid && rnd_ready. rnd_ready while empty is ignored.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Allowed at count==DEPTH and at count==1.
  - At count==1, the new value appears on rnd_out the next cycle.
- Latency:
  - A value pushed at edge N is visible on rnd_out, with rnd_valid=1, after edge N when the FIFO was empty before.
  - Otherwise it is visible after earlier entries are popped.
- rnd_out: always equals the FIFO head. It is 0 after reset. When empty it holds the last head value; consumers must not rely on it while empty.
- Ordering: strictly FIFO. Pointers wrap modulo DEPTH.
- Stuck detection, active only when enable=1:
  - Compare rnd_in with the previous sampled value (prev_sample, updated every enabled cycle).
  - Equal: run counter increments, saturating at STUCK_CYCLES. Different: run counter returns to 0.
  - stuck=1 once the counter reaches STUCK_CYCLES-1 equal comparisons, i.e. STUCK_CYCLES identical consecutive samples.
  - stuck stays set until reset.
  - stuck does not block sampling.
  - The first enabled cycle after reset compares against prev_sample=0. An all-zero LFSR therefore raises stuck after STUCK_CYCLES-1 enabled cycles.
- limit changes: take effect on the same-cycle compare. Already-buffered values are not re-checked.

Test Plan:
1. Basic accept/order:
   - Stimulus: reset 2 cycles, then limit=0, enable=1, rnd_ready=0, rnd_in driven 0x5A, 0x2D, 0x96, 0x4B on four edges.
   - Required: count=4, rnd_valid=1, rnd_out=0x5A. A fifth sample 0x25 is dropped, count stays 4.
   - Then rnd_ready=1, enable=0: outputs 0x5A, 0x2D, 0x96, 0x4B on successive cycles, then rnd_valid=0 and count=0.
2. Rejection:
   - Stimulus: limit=6, rnd_in sequence 0x03, 0x06, 0xFF, 0x05.
   - Required: only 0x03 and 0x05 are buffered; reject_cnt=2.
   - Drive 300 rejects: reject_cnt saturates at 255.
3. Full with simultaneous push/pop:
   - Stimulus: fill to 4, then rnd_ready=1 with in-range rnd_in=0x11 in the same cycle.
   - Required: count stays 4, head advances, and 0x11 is the last value out.
4. Stuck detection:
   - Stimulus: enable=1, rnd_in held at 0x00 after reset.
   - Required: stuck=1 after edge 3, i.e. STUCK_CYCLES-1 edges.
   - Stimulus: change rnd_in to 0xB8. Required: stuck remains 1.
   - Stimulus: reset. Required: stuck=0.
   - Stimulus: alternating 0x01/0x02. Required: stuck never sets.
5. Reset mid-operation:
   - Stimulus: with count=3 and enable=1, assert reset for 1 cycle.
   - Required: the next cycle shows count=0, rnd_valid=0, rnd_out=0, reject_cnt=0, and the sample in the reset cycle is not pushed.
6. Live LFSR hookup:
   - Stimulus: instantiate `lfsr` with seed=0x01, limit=0, rnd_ready=1, run 255 enabled cycles.
   - Required: 255 distinct non-zero values are popped, and stuck stays 0.
